// File: rtl/rv32_pkg.sv
// ---------------------------------------------------------------------------
// rv32_pkg
//   Shared definitions for the RV32M multi-cycle divide unit.
//   - funct_e : M-extension divide/remainder function codes
//   - state_e : divider FSM state encoding
//   - helpers : decode of signedness and quotient/remainder selection
// ---------------------------------------------------------------------------
package rv32_pkg;

  typedef enum logic [1:0] {
    FN_DIV  = 2'b00,
    FN_DIVU = 2'b01,
    FN_REM  = 2'b10,
    FN_REMU = 2'b11
  } funct_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

  // Bit 0 of the function code selects unsigned operation.
  function automatic logic fn_is_signed(input logic [1:0] funct);
    return ~funct[0];
  endfunction

  // Bit 1 of the function code selects the remainder as the result.
  function automatic logic fn_is_rem(input logic [1:0] funct);
    return funct[1];
  endfunction

endpackage

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step
//   One combinational iteration of a radix-2 restoring divider.
//   Shifts {rem, quo} left by one, trial-subtracts the divisor from the
//   partial remainder and keeps the difference when it is non-negative.
//
// Ports
//   rem      in   XLEN  partial remainder (always < dvs on entry)
//   quo      in   XLEN  quotient/dividend shift register
//   dvs      in   XLEN  divisor magnitude (non-zero)
//   rem_nxt  out  XLEN  partial remainder after this iteration
//   quo_nxt  out  XLEN  shift register with the new quotient bit in bit 0
// ---------------------------------------------------------------------------
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] dvs,
  output logic [XLEN-1:0] rem_nxt,
  output logic [XLEN-1:0] quo_nxt
);

  logic [XLEN:0]        shifted;
  logic signed [XLEN:0] trial;
  logic                 trial_ge;

  // Because rem < dvs on entry, shifted < 2*dvs, so the true difference lies
  // in (-dvs, dvs) and always fits an XLEN+1-bit signed value: bit XLEN is a
  // valid sign even though shifted itself may use all XLEN+1 bits.
  always_comb begin
    shifted  = {rem, quo[XLEN-1]};
    trial    = $signed(shifted - {1'b0, dvs});
    trial_ge = (trial >= 0);
    quo_nxt  = {quo[XLEN-2:0], trial_ge};
    rem_nxt  = trial_ge ? trial[XLEN-1:0] : shifted[XLEN-1:0];
  end

endmodule

// File: rtl/seq_div_rem.sv
// ---------------------------------------------------------------------------
// seq_div_rem
//   Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//   Sits beside the ALU in EX; the core stalls EX while Busy is high and
//   captures Result on the single-cycle Done pulse.
//   Flow: IDLE -(accept)-> CALC (XLEN iterations) -> FIX (sign fix) -> IDLE.
//   Divide-by-zero and signed overflow skip CALC and finish in one edge.
//
// Ports
//   CLK     in   1     clock, rising edge
//   RST     in   1     asynchronous active-high reset
//   Start   in   1     op request, accepted only while idle
//   Flush   in   1     abort any op in flight (wins over Start)
//   Funct   in   2     00 DIV, 01 DIVU, 10 REM, 11 REMU
//   Rs1     in   XLEN  dividend, sampled on the accept edge
//   Rs2     in   XLEN  divisor, sampled on the accept edge
//   Busy    out  1     high whenever the FSM is not idle
//   Done    out  1     one-cycle pulse, Result valid
//   Result  out  XLEN  quotient or remainder, held until the next FIX edge
// ---------------------------------------------------------------------------
module seq_div_rem
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            Start,
  input  logic            Flush,
  input  logic [1:0]      Funct,
  input  logic [XLEN-1:0] Rs1,
  input  logic [XLEN-1:0] Rs2,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] Result
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};

  // Two's-complement negate when en is set. The most negative value maps to
  // itself, which read as unsigned is exactly its magnitude.
  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] x,
                                             input logic            en);
    logic signed [XLEN-1:0] sx;
    sx = $signed(x);
    return en ? $unsigned(-sx) : x;
  endfunction

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       funct_q;
  logic [XLEN-1:0]  quo, rem, dvs;
  logic             neg_q, neg_r;
  logic [XLEN-1:0]  result_q;
  logic             done_q;

  logic             signed_op;
  logic             rs1_neg, rs2_neg;
  logic [XLEN-1:0]  rs1_mag, rs2_mag;
  logic             div_zero, sgn_ovf, special;
  logic [XLEN-1:0]  rem_step, quo_step;
  logic [XLEN-1:0]  fix_val;

  // Operand decode for the accept edge
  assign signed_op = fn_is_signed(Funct);
  assign rs1_neg   = signed_op & Rs1[XLEN-1];
  assign rs2_neg   = signed_op & Rs2[XLEN-1];
  assign rs1_mag   = neg_if(Rs1, rs1_neg);
  assign rs2_mag   = neg_if(Rs2, rs2_neg);
  assign div_zero  = (Rs2 == '0);
  assign sgn_ovf   = signed_op & (Rs1 == MIN_VAL) & (Rs2 == '1);
  assign special   = div_zero | sgn_ovf;

  div_step #(.XLEN(XLEN)) u_step (
    .rem     (rem),
    .quo     (quo),
    .dvs     (dvs),
    .rem_nxt (rem_step),
    .quo_nxt (quo_step)
  );

  // Sign fix: the neg flags are already zero for unsigned ops, the signed
  // gate only keeps the decision local to the latched function code.
  always_comb begin
    if (fn_is_rem(funct_q)) begin
      fix_val = neg_if(rem, neg_r & fn_is_signed(funct_q));
    end else begin
      fix_val = neg_if(quo, neg_q & fn_is_signed(funct_q));
    end
  end

  // FSM state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    if (Flush) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (Start) state_nxt = special ? ST_FIX : ST_CALC;
        ST_CALC: if (cnt == CNT_LAST) state_nxt = ST_FIX;
        ST_FIX:  state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Operand, iteration and result registers.
  // Special cases preload the quotient/remainder registers so the common FIX
  // step produces the RISC-V defined answer: for x/0 the remainder register
  // holds |x| with neg_r = sign(x), which the FIX negate turns back into x.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt      <= '0;
      funct_q  <= '0;
      quo      <= '0;
      rem      <= '0;
      dvs      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!Flush) begin
        case (state)
          ST_IDLE: begin
            if (Start) begin
              funct_q <= Funct;
              cnt     <= '0;
              dvs     <= rs2_mag;
              if (div_zero) begin
                quo   <= '1;
                rem   <= rs1_mag;
                neg_q <= 1'b0;
                neg_r <= rs1_neg;
              end else if (sgn_ovf) begin
                quo   <= MIN_VAL;
                rem   <= '0;
                neg_q <= 1'b0;
                neg_r <= 1'b0;
              end else begin
                quo   <= rs1_mag;
                rem   <= '0;
                neg_q <= rs1_neg ^ rs2_neg;
                neg_r <= rs1_neg;
              end
            end
          end
          ST_CALC: begin
            rem <= rem_step;
            quo <= quo_step;
            cnt <= cnt + 1'b1;
          end
          ST_FIX: begin
            result_q <= fix_val;
            done_q   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign Busy   = (state != ST_IDLE);
  assign Done   = done_q;
  assign Result = result_q;

endmodule

// File: tb/tb_seq_div_rem.sv
module tb_seq_div_rem;

  logic        CLK = 1'b0;
  logic        RST, Start, Flush;
  logic [1:0]  Funct;
  logic [31:0] Rs1, Rs2;
  logic        Busy, Done;
  logic [31:0] Result;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] res;
  int          lat;
  int          extra;

  seq_div_rem #(.XLEN(32)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .Start  (Start),
    .Flush  (Flush),
    .Funct  (Funct),
    .Rs1    (Rs1),
    .Rs2    (Rs2),
    .Busy   (Busy),
    .Done   (Done),
    .Result (Result)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Wait (bounded) for Done after an accept edge; lat counts edges after it.
  task automatic wait_done(output logic [31:0] r, output int l);
    l = 0;
    while (!Done && l < 100) begin
      @(posedge CLK); #1;
      l++;
    end
    check("done_seen", 32'(Done), 32'd1);
    r = Result;
  endtask

  task automatic run_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output int l);
    Funct = f; Rs1 = a; Rs2 = b; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    wait_done(r, l);
  endtask

  task automatic count_stray(input int n, output int cnt_o);
    cnt_o = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge CLK); #1;
      if (Done) cnt_o++;
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'd0 : 32'h8000_0000;
    case (f)
      2'b00:   return 32'($signed(a) / $signed(b));
      2'b01:   return a / b;
      2'b10:   return 32'($signed(a) % $signed(b));
      default: return a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    RST = 1'b1; Start = 1'b0; Flush = 1'b0; Funct = 2'b00; Rs1 = '0; Rs2 = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_result", Result, 32'd0);
    RST = 1'b0;
    @(posedge CLK); #1;

    // Unsigned divide / remainder
    run_op(2'b01, 32'd100, 32'd7, res, lat);
    check("divu_lat", 32'(lat), 32'd33);
    check("divu_res", res, 32'd14);
    @(posedge CLK); #1;
    check("done_pulse_drop", 32'(Done), 32'd0);
    check("busy_after_done", 32'(Busy), 32'd0);
    run_op(2'b11, 32'd100, 32'd7, res, lat);
    check("remu_res", res, 32'd2);

    // Signed divide / remainder
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, res, lat);
    check("div_neg_res", res, 32'hFFFF_FFFD);
    check("div_neg_lat", 32'(lat), 32'd33);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, res, lat);
    check("rem_neg_res", res, 32'hFFFF_FFFF);

    // Divide by zero
    run_op(2'b00, 32'h0000_1234, 32'd0, res, lat);
    check("div0_lat", 32'(lat), 32'd1);
    check("div0_res", res, 32'hFFFF_FFFF);
    run_op(2'b10, 32'h0000_1234, 32'd0, res, lat);
    check("rem0_res", res, 32'h0000_1234);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd0, res, lat);
    check("rem0_neg_res", res, 32'hFFFF_FFF9);
    run_op(2'b01, 32'h0000_1234, 32'd0, res, lat);
    check("divu0_res", res, 32'hFFFF_FFFF);

    // Signed overflow
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, res, lat);
    check("ovf_lat", 32'(lat), 32'd1);
    check("ovf_div_res", res, 32'h8000_0000);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, res, lat);
    check("ovf_rem_res", res, 32'd0);

    // Start pulsed while busy is ignored
    Funct = 2'b01; Rs1 = 32'd100; Rs2 = 32'd7; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    repeat (4) begin @(posedge CLK); #1; end
    Funct = 2'b11; Rs1 = 32'd50; Rs2 = 32'd5; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    lat = 5;
    while (!Done && lat < 100) begin @(posedge CLK); #1; lat++; end
    check("busy_start_lat", 32'(lat), 32'd33);
    check("busy_start_res", Result, 32'd14);
    count_stray(40, extra);
    check("busy_start_stray", 32'(extra), 32'd0);

    // Back-to-back: Start held through the Done cycle
    Funct = 2'b01; Rs1 = 32'd100; Rs2 = 32'd7; Start = 1'b1;
    @(posedge CLK); #1;
    Funct = 2'b11; Rs1 = 32'd95; Rs2 = 32'd9;
    lat = 0;
    while (!Done && lat < 100) begin @(posedge CLK); #1; lat++; end
    check("b2b_first_lat", 32'(lat), 32'd33);
    check("b2b_first_res", Result, 32'd14);
    @(posedge CLK); #1;
    Start = 1'b0;
    check("b2b_busy", 32'(Busy), 32'd1);
    check("b2b_done_drop", 32'(Done), 32'd0);
    wait_done(res, lat);
    check("b2b_second_lat", 32'(lat), 32'd33);
    check("b2b_second_res", res, 32'd5);

    // Flush at cycle 10
    Funct = 2'b01; Rs1 = 32'd100; Rs2 = 32'd7; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    repeat (9) begin @(posedge CLK); #1; end
    Flush = 1'b1;
    @(posedge CLK); #1;
    Flush = 1'b0;
    check("flush_busy", 32'(Busy), 32'd0);
    check("flush_done", 32'(Done), 32'd0);
    check("flush_result", Result, 32'd5);
    count_stray(40, extra);
    check("flush_stray", 32'(extra), 32'd0);

    // Flush wins over Start on the same edge
    Funct = 2'b01; Rs1 = 32'd9; Rs2 = 32'd3; Start = 1'b1; Flush = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0; Flush = 1'b0;
    check("flush_vs_start_busy", 32'(Busy), 32'd0);

    // Reset mid-operation
    Funct = 2'b00; Rs1 = 32'hFFFF_FFF9; Rs2 = 32'd2; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    repeat (9) begin @(posedge CLK); #1; end
    RST = 1'b1;
    #1;
    check("midrst_busy", 32'(Busy), 32'd0);
    check("midrst_done", 32'(Done), 32'd0);
    check("midrst_result", Result, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    run_op(2'b01, 32'd100, 32'd7, res, lat);
    check("post_rst_res", res, 32'd14);

    // Random operands against the reference model
    for (int i = 0; i < 24; i++) begin
      logic [1:0]  f;
      logic [31:0] a, b, e;
      int          el;
      f  = 2'($urandom_range(0, 3));
      a  = pick();
      b  = pick();
      e  = model(f, a, b);
      el = ((b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
      run_op(f, a, b, res, lat);
      check("rnd_res", res, e);
      check("rnd_lat", 32'(lat), 32'(el));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
